regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 CPU register file among three writeback sources.
  - req0: in-order pipeline WB stage.
  - req1: multi-cycle MUL/DIV unit.
  - req2: load-miss return path.
- Holds a per-register pending-write scoreboard. Decode queries it to stall on RAW hazards against outstanding multi-cycle results.
- Sits between the writeback sources and the register file write port (wen/waddr/wdata).

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers).
- STARVE_LIMIT, 4, consecutive refused cycles before req1/req2 outrank req0; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  3  per-source write request; bit i = source i.
- req_ready  out  3  per-source grant, combinational.
- req_addr0, req_addr1, req_addr2  in  ADDR_WIDTH each  destination register.
- req_data0, req_data1, req_data2  in  DATA_WIDTH each  write data.
- alloc_en  in  1  decode issued a multi-cycle op with a destination.
- alloc_addr  in  ADDR_WIDTH  that destination.
- q_addr1, q_addr2  in  ADDR_WIDTH  decode source operand addresses.
- q_busy1, q_busy2  out  1  operand has a pending write, combinational.
- rf_wen  out  1  register file write enable, registered.
- rf_waddr  out  ADDR_WIDTH  registered.
- rf_wdata  out  DATA_WIDTH  registered.

Behaviour:
- Reset, sync, active-high:
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All pending bits=0, both starve counters=0, rr pointer=req1.
  - req_ready is 0 during the reset cycle.
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - Once a source raises valid, it holds valid/addr/data stable until ready.
  - req_ready may depend on req_valid; sources must not derive valid from ready.
- Grant: at most one req_ready bit high per cycle, chosen in this order:
  1. Starved req1/req2 (starve_cnt >= STARVE_LIMIT). If both are starved, the rr pointer chooses.
  2. req0.
  3. Non-starved req1/req2, chosen by the rr pointer.
- rr pointer: after a grant to req1 it points to req2; after a grant to req2 it points to req1; otherwise unchanged.
- starve_cnt (req1, req2 only):
  - +1, saturating at STARVE_LIMIT, when valid && !ready.
  - Cleared when granted or when not valid.
- Output latency: a grant in cycle N drives rf_wen/rf_waddr/rf_wdata in cycle N+1. With no grant, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
- Register 0: a grant with addr 0 is accepted (ready=1) but rf_wen stays 0.
- Scoreboard:
  - alloc_en with alloc_addr != 0 sets pending[alloc_addr] at the clock edge; alloc to 0 is ignored.
  - pending[rf_waddr] clears at the edge ending a cycle where rf_wen=1. Net effect: grant in N, register file written at end of N+1, busy low from N+2.
  - If alloc and clear hit the same address on the same edge, alloc wins and the bit stays set.
  - A second alloc to an already-pending register leaves it set; the first matching write clears it.
  - req0 writes also clear a pending bit if their address matches. The scoreboard does not track the source.
- q_busy: q_busyK = pending[q_addrK]; always 0 for address 0. There is no bypass; decode stalls while busy.
- Reset mid-operation: in-flight grants and pending bits are discarded; sources must re-present after reset.

Decomposition:
- Shared package (cpu_defs):
  - DATA_WIDTH, ADDR_WIDTH.
  - Source index constants WB_SRC_PIPE=0, WB_SRC_MDU=1, WB_SRC_LOAD=2.
  - STARVE_LIMIT default.
- Sub-module wb_scoreboard: pending vector, alloc/clear logic, two query ports. The arbiter instantiates it and feeds the registered rf_wen/rf_waddr to it as the clear inputs.

Test Plan:
- Reset checks: assert rst with all req_valid=3'b111 -> req_ready=0 and rf_wen=0 during reset; on the first cycle after, req_ready=3'b001 and the following cycle rf_wen=1 with req_addr0/req_data0.
- Arbitration and latency: req0 only (addr 5, data 0x1234) in cycle N -> ready0=1 in N; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in N+1; rf_wen=0 in N+2.
- Starvation: req0 and req1 (addr 7) held valid continuously with STARVE_LIMIT=4 -> req0 granted 4 cycles, req1 granted in cycle 5, then req0 again.
- Round-robin: req1 and req2 valid, req0 idle -> grants alternate req1, req2, req1 starting from the reset pointer.
- Scoreboard: alloc 9 in N; q_addr1=9 -> q_busy1=1 from N+1; req1 addr 9 granted in M -> rf_wen in M+1, q_busy1=0 from M+2. alloc 9 in the same cycle as rf_wen for 9 -> stays busy.
- Register 0: req2 addr 0 valid -> ready2=1, rf_wen stays 0; alloc 0 -> q_busy for 0 stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths, source ids and starvation helper for the writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int STARVE_LIMIT = 4;
  localparam int NUM_SRC      = 3;

  typedef enum logic [1:0] {
    WB_SRC_PIPE = 2'd0,
    WB_SRC_MDU  = 2'd1,
    WB_SRC_LOAD = 2'd2,
    WB_SRC_NONE = 2'd3
  } wb_src_e;

  // Refused cycles counter: cleared when idle or granted, saturates at the limit.
  function automatic logic [3:0] starve_next(input logic valid, input logic granted,
                                             input logic [3:0] cnt, input logic [3:0] limit);
    if (!valid || granted) return 4'd0;
    if (cnt >= limit) return limit;
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, decode query and register file write bundle
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) ();

  logic [NUM_SRC-1:0] req_valid;
  logic [NUM_SRC-1:0] req_ready;
  logic [AW-1:0]      req_addr0;
  logic [AW-1:0]      req_addr1;
  logic [AW-1:0]      req_addr2;
  logic [DW-1:0]      req_data0;
  logic [DW-1:0]      req_data1;
  logic [DW-1:0]      req_data2;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [AW-1:0]      q_addr1;
  logic [AW-1:0]      q_addr2;
  logic               q_busy1;
  logic               q_busy2;
  logic               rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_addr2,
    input  req_data0, req_data1, req_data2,
    input  alloc_en, alloc_addr, q_addr1, q_addr2,
    output req_ready, q_busy1, q_busy2, rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_addr2,
    output req_data0, req_data1, req_data2,
    output alloc_en, alloc_addr, q_addr1, q_addr2,
    input  req_ready, q_busy1, q_busy2, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - per-register pending-write bits with two decode query ports
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = regfile_wb_arbiter_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc_en,
  input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic [ADDR_WIDTH-1:0] i_q_addr1,
  input  logic [ADDR_WIDTH-1:0] i_q_addr2,
  output logic                  o_busy1,
  output logic                  o_busy2
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] r_pending;

  // The set is written after the clear so a same-edge alloc keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (i_clr_en) r_pending[i_clr_addr] <= 1'b0;
      if (i_alloc_en && (i_alloc_addr != '0)) r_pending[i_alloc_addr] <= 1'b1;
    end
  end

  assign o_busy1 = (i_q_addr1 != '0) && r_pending[i_q_addr1];
  assign o_busy2 = (i_q_addr2 != '0) && r_pending[i_q_addr2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - three-source register file write port arbiter with starvation escape and RAW scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = regfile_wb_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = regfile_wb_arbiter_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = regfile_wb_arbiter_pkg::STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave wb
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            r_starve1;
  logic [3:0]            r_starve2;
  logic                  r_rr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_starved1;
  logic                  w_starved2;
  wb_src_e               w_rr_src;
  wb_src_e               w_src;
  logic [2:0]            w_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // r_rr low means req1 is next in the rotation, high means req2.
  always_comb begin
    w_starved1 = wb.req_valid[WB_SRC_MDU] && (r_starve1 >= LIMIT);
    w_starved2 = wb.req_valid[WB_SRC_LOAD] && (r_starve2 >= LIMIT);
    w_rr_src   = r_rr ? WB_SRC_LOAD : WB_SRC_MDU;
    w_src      = WB_SRC_NONE;
    if (rst)                                     w_src = WB_SRC_NONE;
    else if (w_starved1 && w_starved2)           w_src = w_rr_src;
    else if (w_starved1)                         w_src = WB_SRC_MDU;
    else if (w_starved2)                         w_src = WB_SRC_LOAD;
    else if (wb.req_valid[WB_SRC_PIPE])          w_src = WB_SRC_PIPE;
    else if (wb.req_valid[WB_SRC_MDU] && wb.req_valid[WB_SRC_LOAD]) w_src = w_rr_src;
    else if (wb.req_valid[WB_SRC_MDU])           w_src = WB_SRC_MDU;
    else if (wb.req_valid[WB_SRC_LOAD])          w_src = WB_SRC_LOAD;
  end

  always_comb begin
    w_ready = 3'b000;
    w_addr  = wb.req_addr0;
    w_data  = wb.req_data0;
    case (w_src)
      WB_SRC_PIPE: w_ready[0] = 1'b1;
      WB_SRC_MDU: begin
        w_ready[1] = 1'b1;
        w_addr     = wb.req_addr1;
        w_data     = wb.req_data1;
      end
      WB_SRC_LOAD: begin
        w_ready[2] = 1'b1;
        w_addr     = wb.req_addr2;
        w_data     = wb.req_data2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_starve1 <= 4'd0;
      r_starve2 <= 4'd0;
      r_rr      <= 1'b0;
    end else begin
      // Writes to register 0 are accepted and dropped here.
      r_wen <= (w_src != WB_SRC_NONE) && (w_addr != '0);
      if (w_src != WB_SRC_NONE) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
      r_starve1 <= starve_next(wb.req_valid[WB_SRC_MDU], w_src == WB_SRC_MDU, r_starve1, LIMIT);
      r_starve2 <= starve_next(wb.req_valid[WB_SRC_LOAD], w_src == WB_SRC_LOAD, r_starve2, LIMIT);
      if (w_src == WB_SRC_MDU)       r_rr <= 1'b1;
      else if (w_src == WB_SRC_LOAD) r_rr <= 1'b0;
    end
  end

  regfile_wb_arbiter_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_en   (wb.alloc_en),
    .i_alloc_addr (wb.alloc_addr),
    .i_clr_en     (r_wen),
    .i_clr_addr   (r_waddr),
    .i_q_addr1    (wb.q_addr1),
    .i_q_addr2    (wb.q_addr2),
    .o_busy1      (wb.q_busy1),
    .o_busy2      (wb.q_busy2)
  );

  assign wb.req_ready = w_ready;
  assign wb.rf_wen    = r_wen;
  assign wb.rf_waddr  = r_waddr;
  assign wb.rf_wdata  = r_wdata;

endmodule
